pulse_burst_controller: RTL and testbench
=========================================

# pulse_burst_controller

Sequences a periodic pulse timebase to emit a programmed burst of exactly C pulses spaced P clocks apart, then signals completion. Host side is a start/ready handshake with period and count operands latched at acceptance. An abort input cancels a burst in flight. Sits between a control FSM or register block and anything that consumes pulse-per-period strobes, such as stepper drivers, sample triggers or LED strobes.

## Interface

**Parameters**
- `N`, default 8: width of the period operand.
- `M`, default 8: width of the pulse count operand and of `remaining`.

**Ports**
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  burst request; accepted only when `ready` is high.
- `period`  in  N  pulse spacing P in clocks; 0 means 2^N.
- `count`  in  M  number of pulses C in the burst.
- `abort`  in  1  cancel the running burst; ignored outside RUN.
- `ready`  out  1  high in IDLE when `rst` is low; start is accepted when `start & ready`.
- `busy`  out  1  high in RUN.
- `pulse`  out  1  one-cycle strobe per burst pulse.
- `done`  out  1  one-cycle strobe after the final pulse of a non-aborted burst.
- `remaining`  out  M  pulses still to emit.

## Operation

**States:** IDLE, RUN, DONE.

**IDLE**
- `ready = 1`.
- On `start`:
  - latch `period` into `per_q` and `count` into `remaining`;
  - clear the timebase;
  - go to RUN if C≠0, otherwise go to DONE.
- Operand inputs are don't-care outside the accept cycle.

**RUN**
- Timebase enabled with `ticks = per_q`. `pulse` is the timebase strobe gated by state==RUN and `!abort`.
- On each `pulse`, `remaining` decrements by 1.
- When `pulse` fires with `remaining == 1`, go to DONE. `remaining` becomes 0.
- `abort` in RUN:
  - suppresses `pulse` in that cycle;
  - go to IDLE with no `done`;
  - clear the timebase;
  - `remaining` is cleared to 0.

**DONE**
- `done = 1` for exactly one cycle, then go to IDLE. `ready` is low in DONE.

**Other rules**
- `start` is not accepted in RUN or DONE and has no effect there.
- `abort` in IDLE or DONE has no effect.
- `rst` dominates all inputs. State goes to IDLE, `remaining` to 0 and `per_q` to 0, and the timebase is cleared.

**Arithmetic**
- `remaining` decrements modulo 2^M but never underflows, because decrement happens only in RUN where `remaining ≥ 1`.
- With P=0 the timebase matches on counter wrap, giving a period of 2^N.

## Timing

- **Reset values (cycle after `rst` high):**
  - `ready = 1` once `rst` is low;
  - `busy = 0`, `pulse = 0`, `done = 0`, `remaining = 0`.
- While `rst` is high, `ready = 0`.
- **Burst timing:**
  - The accept cycle is cycle 0. The timebase counter is 0 in cycle 1.
  - Pulse k (1..C) occurs in cycle k·P.
  - `done` occurs in cycle C·P+1, and `ready` returns in cycle C·P+2.
  - With C=0, `done` occurs in cycle 1 and `ready` returns in cycle 2.
- **Abort:** abort in cycle t gives `ready` in cycle t+1. A `start` in t+1 is accepted with the same timing as above.
- **Timing of `busy` and `remaining`:** `busy` is high from cycle 1 to the cycle of the last pulse inclusive. `remaining` updates on the clock edge following each pulse.

## Structure

- `pulse_ctrl_pkg`: `typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} pulse_ctrl_state_t`.
- Sub-module: one `pulse_generator` instance (`N` passed through) is the timebase.
  - `ena = (state == S_RUN)`.
  - `rst = rst | accept | abort_run`.
  - `ticks = per_q`.
- Controller RTL holds the FSM, the `per_q` register and the `remaining` down-counter.

## Test plan

1. P=4, C=3, start at cycle 0 → `pulse` at cycles 4, 8, 12; `remaining` 3→2→1→0; `done` at 13; `ready` at 14.
2. P=1, C=5 → `pulse` high in cycles 1–5 contiguously; `done` at 6; change `period` and `count` mid-burst → no effect.
3. C=0, P=7 → no `pulse`; `done` at cycle 1; `busy` never high; `ready` at cycle 2.
4. P=4, C=3, `abort` at cycle 6 → single `pulse` at 4; no `done`; `ready` at 7. New start at 7 with P=2, C=1 → `pulse` at 9, `done` at 10.
5. P=3, C=4, `rst` at cycle 5 → from cycle 6 all outputs are at reset values and no further pulses occur. After reset release, start with P=2, C=2 → pulses at 2 and 4 relative to the new accept.
6. N=4, P=0, C=2 → pulses at cycles 16 and 32; `start` held high throughout → exactly one burst accepted per IDLE visit.

Source files
------------

// File: rtl/pulse_ctrl_pkg.sv
// Shared types for the pulse burst controller and its timebase.
package pulse_ctrl_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} pulse_ctrl_state_t;
endpackage

// File: rtl/pulse_generator.sv
// Free-running period timebase: strobes once every `ticks` enabled clocks (0 = 2^N).
// Latency: first strobe in the ticks-th enabled cycle after a clear; no backpressure.
module pulse_generator #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic [N-1:0] ticks,
   output logic         strobe
);
   logic [N-1:0] cnt;
   logic [N-1:0] last;

   // ticks == 0 makes last all-ones, so the match lands on the natural wrap.
   assign last   = ticks - N'(1);
   assign strobe = ena && (cnt == last);

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (ena)
         cnt <= strobe ? '0 : cnt + N'(1);
   end
endmodule

// File: rtl/pulse_burst_controller.sv
// Emits a burst of `count` pulses spaced `period` clocks apart, then a one-cycle done.
// Start accepted only while ready (IDLE); abort cancels a running burst with no done.
module pulse_burst_controller
   import pulse_ctrl_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] period,
   input  logic [M-1:0] count,
   input  logic         abort,
   output logic         ready,
   output logic         busy,
   output logic         pulse,
   output logic         done,
   output logic [M-1:0] remaining
);
   pulse_ctrl_state_t state;
   logic [N-1:0]      per_q;
   logic              accept;
   logic              abort_run;
   logic              tb_strobe;

   assign accept    = start && ready;
   assign abort_run = abort && (state == S_RUN);
   assign ready     = (state == S_IDLE) && !rst;
   assign busy      = (state == S_RUN);
   assign done      = (state == S_DONE);
   assign pulse     = tb_strobe && (state == S_RUN) && !abort;

   pulse_generator #(.N(N)) u_timebase (
      .clk    (clk),
      .rst    (rst | accept | abort_run),
      .ena    (state == S_RUN),
      .ticks  (per_q),
      .strobe (tb_strobe)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         per_q     <= '0;
         remaining <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  per_q     <= period;
                  remaining <= count;
                  state     <= (count == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state     <= S_IDLE;
                  remaining <= '0;
               end else if (pulse) begin
                  remaining <= remaining - M'(1);
                  if (remaining == M'(1))
                     state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pulse_burst_controller.sv
// Scoreboard bench: each accepted burst queues its pulse/done events by cycle; a monitor pops and compares.
module tb_pulse_burst_controller;
   localparam int N = 4;
   localparam int M = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [N-1:0] period = '0;
   logic [M-1:0] count = '0;
   logic         ready, busy, pulse, done;
   logic [M-1:0] remaining;

   pulse_burst_controller #(.N(N), .M(M)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .period    (period),
      .count     (count),
      .abort     (abort),
      .ready     (ready),
      .busy      (busy),
      .pulse     (pulse),
      .done      (done),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int at;
      bit is_done;
   } ev_t;

   ev_t q[$];
   int  free_at = 0;
   int  busy_from = 1;
   int  busy_to = 0;
   int  m_rem = 0;
   int  exp_rem = 0;
   bit  exp_ready = 1'b0;
   bit  exp_busy = 1'b0;
   bit  mon_en = 1'b0;
   int  n_chk = 0;
   int  n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic bit pulse_due(input int at);
      foreach (q[i])
         if (q[i].at == at && !q[i].is_done) return 1'b1;
      return 1'b0;
   endfunction

   // Reference: a burst accepted in cycle a pulses at a+k*P and is done at a+C*P+1.
   task automatic model_cycle();
      exp_ready = !rst && (cyc >= free_at);
      exp_busy  = (cyc >= busy_from) && (cyc <= busy_to);
      exp_rem   = m_rem;
      if (rst) begin
         while (q.size() > 0 && q[$].at > cyc) void'(q.pop_back());
         if (busy_to > cyc) busy_to = cyc;
         free_at = cyc + 1;
         m_rem   = 0;
      end else if (abort && exp_busy) begin
         while (q.size() > 0 && q[$].at >= cyc) void'(q.pop_back());
         busy_to = cyc;
         free_at = cyc + 1;
         m_rem   = 0;
      end else if (start && exp_ready) begin
         int p;
         int c;
         p = (period == '0) ? (1 << N) : int'(period);
         c = int'(count);
         for (int k = 1; k <= c; k++) q.push_back('{cyc + k * p, 1'b0});
         q.push_back('{cyc + c * p + 1, 1'b1});
         busy_from = cyc + 1;
         busy_to   = cyc + c * p;
         free_at   = cyc + c * p + 2;
         m_rem     = c;
      end else if (pulse_due(cyc)) begin
         m_rem = m_rem - 1;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mon_en) begin
            chk("ready", int'(ready), int'(exp_ready));
            chk("busy", int'(busy), int'(exp_busy));
            chk("remaining", int'(remaining), exp_rem);
            if (q.size() > 0 && q[0].at == cyc) begin
               chk("pulse", int'(pulse), int'(!q[0].is_done));
               chk("done", int'(done), int'(q[0].is_done));
               void'(q.pop_front());
            end else begin
               chk("pulse", int'(pulse), 0);
               chk("done", int'(done), 0);
            end
         end
      end
   end

   // Reset requests are dropped in cycles where a pulse is due, so the model stays unambiguous.
   task automatic step(input bit s, input bit a, input bit r,
                       input logic [N-1:0] p, input logic [M-1:0] c);
      @(negedge clk);
      start  = s;
      abort  = a;
      rst    = r && !pulse_due(cyc);
      period = p;
      count  = c;
      model_cycle();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, N'($urandom), M'($urandom));
   endtask

   task automatic wait_free();
      for (int i = 0; i < 300 && (cyc + 1 < free_at); i++) idle(1);
   endtask

   initial begin
      step(1'b0, 1'b0, 1'b1, '0, '0);
      mon_en = 1'b1;
      step(1'b0, 1'b0, 1'b1, '0, '0);
      step(1'b0, 1'b0, 1'b1, '0, '0);
      idle(2);

      // P=4, C=3
      step(1'b1, 1'b0, 1'b0, 4'd4, 8'd3);
      wait_free();
      // P=1, C=5 with operands changing mid-burst
      step(1'b1, 1'b0, 1'b0, 4'd1, 8'd5);
      idle(3);
      wait_free();
      // C=0
      step(1'b1, 1'b0, 1'b0, 4'd7, 8'd0);
      wait_free();
      // abort at relative cycle 6, restart at 7
      step(1'b1, 1'b0, 1'b0, 4'd4, 8'd3);
      idle(5);
      step(1'b0, 1'b1, 1'b0, 4'd4, 8'd3);
      step(1'b1, 1'b0, 1'b0, 4'd2, 8'd1);
      wait_free();
      // reset mid-burst, then a fresh burst
      step(1'b1, 1'b0, 1'b0, 4'd3, 8'd4);
      idle(4);
      step(1'b0, 1'b0, 1'b1, 4'd3, 8'd4);
      step(1'b1, 1'b0, 1'b0, 4'd2, 8'd2);
      wait_free();
      // P=0 (2^N) with start held high
      repeat (80) step(1'b1, 1'b0, 1'b0, 4'd0, 8'd2);
      idle(1);
      wait_free();
      idle(2);

      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) == 0,
              $urandom_range(0, 29) == 0,
              $urandom_range(0, 199) == 0,
              ($urandom_range(0, 4) == 0) ? N'($urandom) : N'($urandom_range(0, 5)),
              M'($urandom_range(0, 4)));
      end
      idle(1);
      wait_free();
      idle(3);
      chk("events_outstanding", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
